// File: rtl/jedro_1_ctrl.sv
// jedro_1 core sequencing FSM: one instruction at a time through fetch/decode/execute/mem/writeback.
// Optional MEM_WAIT watchdog enabled by defining JEDRO_1_CTRL_TIMEOUT_EN.
module jedro_1_ctrl #(
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR   = 32'h0000_0100,
  parameter int          LSU_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        ifu_get_next_o,
  input  logic        ifu_valid_i,
  output logic        ifu_jmp_o,
  output logic [31:0] ifu_jmp_addr_o,
  input  logic        dec_illegal_i,
  input  logic        dec_jump_i,
  input  logic [31:0] dec_jmp_target_i,
  input  logic        dec_lsu_i,
  input  logic        dec_wb_i,
  output logic        lsu_start_o,
  input  logic        lsu_done_i,
  input  logic        lsu_err_i,
  output logic        rf_we_o,
  output logic        trap_o,
  output logic [3:0]  trap_cause_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] pc_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXECUTE, S_MEM_WAIT, S_WRITEBACK, S_TRAP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, instret, trap_pc, jmp_target;
  logic [3:0]  cause, cause_nxt;
  logic        is_jump;
  logic        lsu_timeout;

`ifdef JEDRO_1_CTRL_TIMEOUT_EN
  logic [15:0] wait_cnt;
  assign lsu_timeout = (state == S_MEM_WAIT) && !lsu_done_i &&
                       (wait_cnt == 16'(LSU_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i)                     wait_cnt <= '0;
    else if (state == S_EXECUTE)   wait_cnt <= '0;
    else if (state == S_MEM_WAIT)  wait_cnt <= wait_cnt + 16'd1;
  end
`else
  assign lsu_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    cause_nxt      = cause;
    ifu_get_next_o = 1'b0;
    ifu_jmp_o      = 1'b0;
    ifu_jmp_addr_o = '0;
    lsu_start_o    = 1'b0;
    rf_we_o        = 1'b0;
    trap_o         = 1'b0;
    case (state)
      S_BOOT: begin
        ifu_jmp_o      = 1'b1;
        ifu_jmp_addr_o = BOOT_ADDR;
        state_nxt      = S_FETCH;
      end
      S_FETCH: begin
        ifu_get_next_o = 1'b1;
        if (ifu_valid_i) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal_i) begin
          state_nxt = S_TRAP;
          cause_nxt = 4'd2;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (dec_jump_i && (dec_jmp_target_i[1:0] != 2'b00)) begin
          state_nxt = S_TRAP;
          cause_nxt = 4'd0;
        end else if (dec_lsu_i) begin
          lsu_start_o = 1'b1;
          state_nxt   = S_MEM_WAIT;
        end else begin
          state_nxt = S_WRITEBACK;
        end
      end
      S_MEM_WAIT: begin
        // err is only meaningful alongside done; a done in the timeout cycle still retires
        if (lsu_done_i) begin
          if (lsu_err_i) begin
            state_nxt = S_TRAP;
            cause_nxt = 4'd5;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (lsu_timeout) begin
          state_nxt = S_TRAP;
          cause_nxt = 4'd5;
        end
      end
      S_WRITEBACK: begin
        rf_we_o = dec_wb_i;
        if (is_jump) begin
          ifu_jmp_o      = 1'b1;
          ifu_jmp_addr_o = jmp_target;
        end
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        trap_o         = 1'b1;
        ifu_jmp_o      = 1'b1;
        ifu_jmp_addr_o = TRAP_ADDR;
        state_nxt      = S_FETCH;
      end
      default: state_nxt = S_BOOT;
    endcase
    // Keep every strobe quiet while reset is held, BOOT jump fires after release.
    if (rst_i) begin
      ifu_get_next_o = 1'b0;
      ifu_jmp_o      = 1'b0;
      lsu_start_o    = 1'b0;
      rf_we_o        = 1'b0;
      trap_o         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_BOOT;
      pc         <= BOOT_ADDR;
      instret    <= '0;
      trap_pc    <= '0;
      cause      <= '0;
      jmp_target <= '0;
      is_jump    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_EXECUTE) begin
        is_jump    <= dec_jump_i;
        jmp_target <= dec_jmp_target_i;
      end
      // Trap info is captured on entry so it is already valid during the trap_o pulse.
      if (state_nxt == S_TRAP && state != S_TRAP) begin
        trap_pc <= pc;
        cause   <= cause_nxt;
      end
      if (state == S_WRITEBACK) begin
        instret <= instret + 32'd1;
        pc      <= is_jump ? jmp_target : pc + 32'd4;
      end
      if (state == S_TRAP) pc <= TRAP_ADDR;
    end
  end

  assign trap_cause_o = cause;
  assign trap_pc_o    = trap_pc;
  assign pc_o         = pc;
  assign instret_o    = instret;

endmodule

// File: tb/tb_jedro_1_ctrl.sv
// Scoreboard bench for jedro_1_ctrl: directed instructions push expected strobe events,
// a monitor compares every strobe cycle against the queue head.
module tb_jedro_1_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        get_next, ifu_valid = 1'b0, ifu_jmp;
  logic [31:0] jmp_addr;
  logic        illegal = 1'b0, jump = 1'b0, lsu = 1'b0, wb = 1'b0;
  logic [31:0] target = '0;
  logic        lsu_start, lsu_done = 1'b0, lsu_err = 1'b0;
  logic        rf_we, trap;
  logic [3:0]  cause;
  logic [31:0] trap_pc, pc, instret;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          jmp, we, trp, start;
    logic [31:0] addr, pc, instret, tpc;
    logic [3:0]  cause;
  } ev_t;
  ev_t exp_q[$];

  jedro_1_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .ifu_get_next_o(get_next), .ifu_valid_i(ifu_valid),
    .ifu_jmp_o(ifu_jmp), .ifu_jmp_addr_o(jmp_addr),
    .dec_illegal_i(illegal), .dec_jump_i(jump), .dec_jmp_target_i(target),
    .dec_lsu_i(lsu), .dec_wb_i(wb),
    .lsu_start_o(lsu_start), .lsu_done_i(lsu_done), .lsu_err_i(lsu_err),
    .rf_we_o(rf_we), .trap_o(trap), .trap_cause_o(cause), .trap_pc_o(trap_pc),
    .pc_o(pc), .instret_o(instret)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endfunction

  function automatic ev_t mk(bit j, bit w, bit t, bit s, logic [31:0] a,
                             logic [31:0] p, logic [31:0] n, logic [31:0] tp, logic [3:0] c);
    ev_t e;
    e.jmp = j; e.we = w; e.trp = t; e.start = s;
    e.addr = a; e.pc = p; e.instret = n; e.tpc = tp; e.cause = c;
    return e;
  endfunction

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (ifu_jmp || rf_we || trap || lsu_start) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: jmp=%0b we=%0b trap=%0b start=%0b pc=0x%08h",
                 ifu_jmp, rf_we, trap, lsu_start, pc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("strobes", {28'd0, ifu_jmp, rf_we, trap, lsu_start},
              {28'd0, e.jmp, e.we, e.trp, e.start});
        check("ev_pc", pc, e.pc);
        check("ev_instret", instret, e.instret);
        if (e.jmp)  check("jmp_addr", jmp_addr, e.addr);
        if (e.trp) begin
          check("trap_cause", {28'd0, cause}, {28'd0, e.cause});
          check("trap_pc", trap_pc, e.tpc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!get_next && n < 60) begin tick(); n++; end
    if (!get_next) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: get_next=%0b required 1", get_next);
    end
  endtask

  // Issue one instruction; for LSU ops: err_pre gives err without done first,
  // then done after dly cycles (done_never leaves the access hanging).
  task automatic issue(bit il, bit j, logic [31:0] t, bit l, bit w,
                       int dly, bit err, bit err_pre, bit done_never);
    wait_fetch();
    ifu_valid = 1'b1; illegal = il; jump = j; target = t; lsu = l; wb = w;
    tick();
    ifu_valid = 1'b0;
    if (l && !il && !(j && t[1:0] != 2'b00)) begin
      int n = 0;
      while (!lsu_start && n < 10) begin tick(); n++; end
      check("lsu_start_seen", {31'd0, lsu_start}, 32'd1);
      tick();
      if (!done_never) begin
        if (err_pre) begin lsu_err = 1'b1; tick(); lsu_err = 1'b0; end
        repeat (dly) tick();
        lsu_done = 1'b1; lsu_err = err;
        tick();
        lsu_done = 1'b0; lsu_err = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_strobes", {28'd0, ifu_jmp, rf_we, trap, lsu_start}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_trap", {trap_pc[27:0], cause}, 32'h0);

    // BOOT jump to 0x0
    exp_q.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    rst = 1'b0;

    // three ALU ops writing rd
    exp_q.push_back(mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 32'h4, 1, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 32'h8, 2, 0, 0));
    repeat (3) issue(0, 0, 0, 0, 1, 0, 0, 0, 0);
    wait_fetch();
    check("alu_pc", pc, 32'hC);
    check("alu_instret", instret, 32'd3);

    // aligned jump 0xC -> 0x40 with link write
    exp_q.push_back(mk(1, 1, 0, 0, 32'h40, 32'hC, 3, 0, 0));
    issue(0, 1, 32'h40, 0, 1, 0, 0, 0, 0);
    wait_fetch();
    check("jmp_pc", pc, 32'h40);
    check("jmp_instret", instret, 32'd4);

    // misaligned jump at 0x40 -> trap cause 0, no rf write
    exp_q.push_back(mk(1, 0, 1, 0, 32'h100, 32'h40, 4, 32'h40, 4'd0));
    issue(0, 1, 32'h42, 0, 1, 0, 0, 0, 0);
    wait_fetch();
    check("trap0_pc", pc, 32'h100);

    // illegal at 0x100 -> cause 2
    exp_q.push_back(mk(1, 0, 1, 0, 32'h100, 32'h100, 4, 32'h100, 4'd2));
    issue(1, 0, 0, 0, 1, 0, 0, 0, 0);

    // ALU without writeback: silent retire, 0x100 -> 0x104
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_fetch();
    check("nowb_pc", pc, 32'h104);
    check("nowb_instret", instret, 32'd5);

    // jump 0x104 -> 0x20 without rd write
    exp_q.push_back(mk(1, 0, 0, 0, 32'h20, 32'h104, 5, 0, 0));
    issue(0, 1, 32'h20, 0, 0, 0, 0, 0, 0);

    // load at 0x20 faults (done+err) -> cause 5
    exp_q.push_back(mk(0, 0, 0, 1, 0, 32'h20, 6, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 32'h100, 32'h20, 6, 32'h20, 4'd5));
    issue(0, 0, 0, 1, 1, 2, 1, 0, 0);

    // load at 0x100: err without done ignored, then clean done
    exp_q.push_back(mk(0, 0, 0, 1, 0, 32'h100, 6, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 32'h100, 6, 0, 0));
    issue(0, 0, 0, 1, 1, 1, 0, 1, 0);

    // store at 0x104, immediate done
    exp_q.push_back(mk(0, 0, 0, 1, 0, 32'h104, 7, 0, 0));
    issue(0, 0, 0, 1, 0, 0, 0, 0, 0);
    wait_fetch();
    check("lsu_pc", pc, 32'h108);
    check("lsu_instret", instret, 32'd8);
    check("held_cause", {28'd0, cause}, 32'd5);
    check("held_trap_pc", trap_pc, 32'h20);

`ifdef JEDRO_1_CTRL_TIMEOUT_EN
    // load at 0x108 never completes -> watchdog trap cause 5
    exp_q.push_back(mk(0, 0, 0, 1, 0, 32'h108, 8, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 32'h100, 32'h108, 8, 32'h108, 4'd5));
    issue(0, 0, 0, 1, 1, 0, 0, 0, 1);
    begin
      int n = 0;
      while (!trap && n < 40) begin tick(); n++; end
      check("timeout_trap", {31'd0, trap}, 32'd1);
    end
    wait_fetch();
    check("timeout_pc", pc, 32'h100);
`endif

    // reset during MEM_WAIT: abort, back to BOOT, no LSU reissue
    exp_q.push_back(mk(0, 0, 0, 1, 0, pc, instret, 0, 0));
    issue(0, 0, 0, 1, 1, 0, 0, 0, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_strobes", {28'd0, ifu_jmp, rf_we, trap, lsu_start}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_instret", instret, 32'h0);
    exp_q.push_back(mk(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    rst = 1'b0;
    illegal = 1'b0; jump = 1'b0; lsu = 1'b0; wb = 1'b0;
    repeat (10) tick();

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    end
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
